rr_grant_sched: RTL and testbench

- Round-robin scheduler that shares one resource among N requesters.
- Issues a one-hot grant through an enabled, index-addressed decoder: output `idx` carries the enable, all other outputs are 0.
- Holds each grant until the owner releases it or a hold limit expires.
- Sits between requesting units and the shared datapath. Its `gnt` bus drives the datapath select/enable lines directly.

---
 rtl/rr_sched_pkg.sv | 43 ++++
 rtl/rr_grant_sched_dec.sv | 19 +
 rtl/rr_grant_sched.sv | 115 +++++++++++
 tb/tb_rr_grant_sched.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_sched_pkg.sv
// Shared definitions for the round-robin grant scheduler.
//   - sched_state_e : scheduler FSM states (IDLE, GRANT, GAP)
//   - RR_DEFAULT_N / RR_DEFAULT_MAXHOLD : default parameter values
//   - RR_MAX_N      : widest request vector rr_pick can search
//   - rr_pick()     : rotating-priority search used for arbitration
package rr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } sched_state_e;

  localparam int RR_DEFAULT_N       = 4;
  localparam int RR_DEFAULT_MAXHOLD = 8;
  localparam int RR_MAX_N           = 32;

  // Returns the first index i with req[i]=1 when scanning
  // ptr, ptr+1, ..., ptr+n-1 (all mod n). Returns 0 when nothing is
  // requested; callers only use the result when |req is true.
  function automatic int rr_pick(input logic [RR_MAX_N-1:0] req,
                                 input int n,
                                 input int ptr);
    int   win;
    int   cand;
    logic found;
    win   = 0;
    found = 1'b0;
    for (int k = 0; k < RR_MAX_N; k++) begin
      if (k < n && !found) begin
        // Modulo by subtraction: ptr < n and k < n, so one wrap is enough.
        cand = ptr + k;
        if (cand >= n) cand = cand - n;
        if (req[cand]) begin
          win   = cand;
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_grant_sched_dec.sv
// Enabled index-addressed decoder.
//   addr_i : index of the output to drive
//   en_i   : enable; when low every output is 0
//   y_o    : N outputs, y_o[addr_i] = en_i, all others 0
module dec_en_n #(
  parameter int N  = 4,
  parameter int AW = 2
) (
  input  logic [AW-1:0] addr_i,
  input  logic          en_i,
  output logic [N-1:0]  y_o
);

  always_comb begin
    y_o = '0;
    y_o[addr_i] = en_i;
  end

endmodule

// File: rtl/rr_grant_sched.sv
// Round-robin scheduler sharing one resource among N requesters.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   req       : request vector, req[i] held high while i wants the resource
//   done      : one-cycle release pulse from the current owner
//   gnt       : one-hot grant (all zero when no grant)
//   gnt_idx   : index of the current owner, valid while gnt_valid=1
//   gnt_valid : high while a grant is active
//   preempt   : one-cycle pulse when a grant ended by the hold limit
//   dbg_state : current FSM state, for observation only
//
// Handshake: a requester raises req[i] and keeps it high while it wants
// the resource. Once it sees gnt[i] it owns the resource until it drops
// req[i] or pulses done (either, or both in the same cycle, is one
// release). The scheduler may end the grant early after MAXHOLD cycles,
// signalled by preempt. Every grant is followed by one dead cycle (GAP).
import rr_sched_pkg::*;

module rr_grant_sched #(
  parameter int N       = RR_DEFAULT_N,
  parameter int IDXW    = $clog2(N),
  parameter int MAXHOLD = RR_DEFAULT_MAXHOLD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            preempt,
  output logic [1:0]      dbg_state
);

  localparam int HW = (MAXHOLD > 0) ? $clog2(MAXHOLD + 1) : 1;

  sched_state_e    state_q;
  logic [IDXW-1:0] ptr_q;
  logic [IDXW-1:0] idx_q;
  logic [HW-1:0]   hcnt_q;
  logic            preempt_q;

  logic [IDXW-1:0] win;
  logic [IDXW-1:0] ptr_next;
  logic            any_req;
  logic            owner_req;
  logic            hold_hit;

  always_comb begin
    win       = IDXW'(rr_pick(RR_MAX_N'(req), N, int'(ptr_q)));
    any_req   = |req;
    owner_req = req[idx_q];
    // Explicit wrap so non-power-of-two N also returns to 0.
    ptr_next  = (idx_q == IDXW'(N - 1)) ? '0 : idx_q + IDXW'(1);
    // hcnt counts 0..MAXHOLD-1 over the grant, so the grant lasts
    // exactly MAXHOLD cycles when it reaches the limit.
    hold_hit  = (MAXHOLD != 0) && (hcnt_q == HW'(MAXHOLD - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      hcnt_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            idx_q   <= win;
            hcnt_q  <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          hcnt_q <= hcnt_q + HW'(1);
          if (!owner_req || done || hold_hit) begin
            state_q   <= GAP;
            ptr_q     <= ptr_next;
            // Only a limit-forced release counts as a preemption.
            preempt_q <= hold_hit && owner_req && !done;
          end
        end
        GAP: begin
          if (any_req) begin
            idx_q   <= win;
            hcnt_q  <= '0;
            state_q <= GRANT;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_valid = (state_q == GRANT);
  assign gnt_idx   = idx_q;
  assign preempt   = preempt_q;
  assign dbg_state = state_q;

  // Grant is decoded purely from registered state.
  dec_en_n #(
    .N  (N),
    .AW (IDXW)
  ) u_dec (
    .addr_i (idx_q),
    .en_i   (gnt_valid),
    .y_o    (gnt)
  );

endmodule

// File: tb/tb_rr_grant_sched.sv
// Directed bench for rr_grant_sched (N=4, MAXHOLD=8).
import rr_sched_pkg::*;

module tb_rr_grant_sched;

  localparam int N       = 4;
  localparam int IDXW    = 2;
  localparam int MAXHOLD = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic            done;
  logic [N-1:0]    gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_valid;
  logic            preempt;
  logic [1:0]      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [IDXW-1:0] exp_q[$];

  rr_grant_sched #(
    .N       (N),
    .IDXW    (IDXW),
    .MAXHOLD (MAXHOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic check_out(input string tag, input logic [N-1:0] g, input logic v,
                           input logic [IDXW-1:0] i, input logic p);
    check({tag, "_gnt"},     32'(gnt),       32'(g));
    check({tag, "_valid"},   32'(gnt_valid), 32'(v));
    if (v) check({tag, "_idx"}, 32'(gnt_idx), 32'(i));
    check({tag, "_preempt"}, 32'(preempt),   32'(p));
  endtask

  task automatic check_state(input string tag, input sched_state_e s);
    check(tag, 32'(dbg_state), 32'(s));
  endtask

  logic [N-1:0]    eg;
  logic [IDXW-1:0] e;

  initial begin
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    tick();
    tick();
    check_out("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
    check("reset_idx", 32'(gnt_idx), 32'd0);
    check_state("reset_state", IDLE);
    rst = 1'b0;

    // 1: reset mid-grant; ptr moved to 1 first so restart at 0 is visible
    req = 4'b0001;
    tick();
    check_out("t1_g0", 4'b0001, 1'b1, 2'd0, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 4'b0010;
    check_out("t1_gap", 4'b0000, 1'b0, 2'd0, 1'b0);
    tick();
    check_out("t1_g1", 4'b0010, 1'b1, 2'd1, 1'b0);
    rst = 1'b1;
    #1;
    check("t1_async_gnt",   32'(gnt),       32'd0);
    check("t1_async_valid", 32'(gnt_valid), 32'd0);
    check_state("t1_async_state", IDLE);
    tick();
    rst = 1'b0;
    req = 4'b0011;
    tick();
    check_out("t1_restart", 4'b0001, 1'b1, 2'd0, 1'b0);
    req = 4'b0000;
    tick();
    tick();
    check_state("t1_idle", IDLE);

    // 2: single request, held 4 cycles then dropped
    do_reset();
    req = 4'b0100;
    tick();
    check_out("t2_grant", 4'b0100, 1'b1, 2'd2, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out("t2_hold", 4'b0100, 1'b1, 2'd2, 1'b0);
    end
    req = 4'b0000;
    tick();
    check_out("t2_gap", 4'b0000, 1'b0, 2'd0, 1'b0);
    check_state("t2_gap_state", GAP);
    tick();
    check_state("t2_idle", IDLE);
    check("t2_idle_gnt", 32'(gnt), 32'd0);

    // 3: fairness with all requesting and done each grant
    do_reset();
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      e  = exp_q.pop_front();
      eg = '0;
      eg[e] = 1'b1;
      check_out("t3_grant", eg, 1'b1, e, 1'b0);
      done = 1'b1;
      tick();
      done = 1'b0;
      if (k == 4) req = 4'b0000;
      check_out("t3_gap", 4'b0000, 1'b0, 2'd0, 1'b0);
      tick();
    end
    check_state("t3_idle", IDLE);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // 4: preemption by the hold limit
    do_reset();
    req = 4'b0011;
    tick();
    for (int k = 0; k < MAXHOLD; k++) begin
      check_out("t4_own0", 4'b0001, 1'b1, 2'd0, 1'b0);
      tick();
    end
    check_out("t4_gap0", 4'b0000, 1'b0, 2'd0, 1'b1);
    tick();
    for (int k = 0; k < MAXHOLD; k++) begin
      check_out("t4_own1", 4'b0010, 1'b1, 2'd1, 1'b0);
      tick();
    end
    check_out("t4_gap1", 4'b0000, 1'b0, 2'd0, 1'b1);
    tick();
    check_out("t4_own0_again", 4'b0001, 1'b1, 2'd0, 1'b0);
    req = 4'b0000;
    tick();
    check_out("t4_rel_gap", 4'b0000, 1'b0, 2'd0, 1'b0);
    tick();
    check_state("t4_idle", IDLE);

    // 5: owner 3 releases with done and req drop together; ptr wraps to 0
    // ptr is 1 here, so req=1001 selects 3.
    req = 4'b1001;
    tick();
    check_out("t5_own3", 4'b1000, 1'b1, 2'd3, 1'b0);
    done = 1'b1;
    req  = 4'b0001;
    tick();
    done = 1'b0;
    req  = 4'b1001;
    check_out("t5_gap", 4'b0000, 1'b0, 2'd0, 1'b0);
    tick();
    check_out("t5_wrap", 4'b0001, 1'b1, 2'd0, 1'b0);
    req = 4'b0000;
    tick();
    check_out("t5_gap2", 4'b0000, 1'b0, 2'd0, 1'b0);
    tick();

    // 6: spurious done in IDLE and GAP
    done = 1'b1;
    tick();
    done = 1'b0;
    check_state("t6_idle_done", IDLE);
    check("t6_idle_gnt", 32'(gnt), 32'd0);
    req = 4'b0100;
    tick();
    check_out("t6_grant", 4'b0100, 1'b1, 2'd2, 1'b0);
    req = 4'b0000;
    tick();
    check_state("t6_gap", GAP);
    done = 1'b1;
    tick();
    done = 1'b0;
    check_state("t6_after_gap", IDLE);
    check_out("t6_after_gap", 4'b0000, 1'b0, 2'd0, 1'b0);
    tick();
    check_state("t6_stay_idle", IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
